ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, ...) from the controller to the keyboard over the same two open-drain lines the keyboard receiver listens on. Runs the request-to-send sequence, shifts the frame on device-generated clock edges, and checks the device ACK. Sits beside the keyboard receiver. While BUSY=1, the receiver must ignore the lines.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_clk_filter.sv | 59 +++++
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and keyboard receiver.
//   - ps2_state_e    : transmitter FSM states
//   - *_DEF          : default timing constants (100 MHz system clock)
//   - CMD_* / ACK_BYTE : common keyboard command and response codes
//   - make_frame()   : builds the 11-bit host-to-device frame, LSB sent first
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      ACK,
      WAIT_IDLE,
      DONE,
      ERR
   } ps2_state_e;

   localparam int INHIBIT_CYC_DEF = 12000;    // 120 us clock inhibit
   localparam int TIMEOUT_CYC_DEF = 2000000;  // 20 ms from clock release to ACK
   localparam int FILTER_LEN_DEF  = 8;        // ps2c glitch-filter depth

   // Number of extra attempts after a failed transfer when retry is built in.
   localparam logic [1:0] RETRY_MAX = 2'd2;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] ACK_BYTE    = 8'hFA;

   // {stop, odd parity, data[7:0], start}; bit 0 goes on the wire first.
   function automatic logic [10:0] make_frame(input logic [7:0] data);
      return {1'b1, ~^data, data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ---------------------------------------------------------------------------
// ps2_clk_filter
// Synchronises the PS/2 clock line, removes glitches with a FILTER_LEN-sample
// shift filter (output changes only on all-ones / all-zeros) and flags the
// filtered 1->0 transition with a registered one-cycle pulse.
// Shared by the host transmitter and the keyboard receiver.
// Ports:
//   Reloj      in   system clock
//   RST        in   asynchronous active-low reset
//   ps2c_in    in   raw PS/2 clock line level
//   ps2c_filt  out  filtered clock level (idles high)
//   ps2c_fall  out  one-cycle pulse, filtered falling edge
// FILTER_LEN must be at least 2.
// ---------------------------------------------------------------------------
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic Reloj,
   input  logic RST,
   input  logic ps2c_in,
   output logic ps2c_filt,
   output logic ps2c_fall
);

   logic [1:0]            sync_reg;
   logic [FILTER_LEN-1:0] shift_reg;
   logic                  filt_reg;
   logic                  fall_reg;
   logic                  all_ones;
   logic                  all_zeros;

   assign all_ones  = &shift_reg;
   assign all_zeros = ~|shift_reg;

   // The line idles high, so everything resets to 1 to avoid a false fall
   // right after reset.
   always_ff @(posedge Reloj or negedge RST) begin
      if (!RST) begin
         sync_reg  <= 2'b11;
         shift_reg <= '1;
         filt_reg  <= 1'b1;
         fall_reg  <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], ps2c_in};
         shift_reg <= {shift_reg[FILTER_LEN-2:0], sync_reg[1]};
         if (all_ones) begin
            filt_reg <= 1'b1;
         end else if (all_zeros) begin
            filt_reg <= 1'b0;
         end
         // Fires in the same cycle the filtered level first reads 0.
         fall_reg  <= filt_reg & all_zeros;
      end
   end

   assign ps2c_filt = filt_reg;
   assign ps2c_fall = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the clock, issues request-to-send,
// shifts one byte out on device-generated clock falls and checks the device
// ACK. The keyboard receiver must ignore the lines while BUSY=1.
// Ports:
//   Reloj    in   system clock (100 MHz)
//   RST      in   asynchronous active-low reset; releases both lines at once
//   DATA_TX  in   byte to send, sampled when WR=1 in IDLE
//   WR       in   single-cycle send request (ignored while busy)
//   ps2c_in  in   PS/2 clock line level
//   ps2d_in  in   PS/2 data line level
//   ps2c_oe  out  1 = pull clock low
//   ps2d_oe  out  1 = pull data low
//   BUSY     out  transfer in progress
//   TX_DONE  out  one-cycle pulse: byte ACKed
//   TX_ERR   out  one-cycle pulse: NAK or timeout
// Build option: define PS2_TX_RETRY_EN to retry a failed transfer up to two
// more times (re-inhibit with the latched byte) before pulsing TX_ERR.
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
   input  logic       Reloj,
   input  logic       RST,
   input  logic [7:0] DATA_TX,
   input  logic       WR,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       BUSY,
   output logic       TX_DONE,
   output logic       TX_ERR
);

   localparam int INH_W = $clog2(INHIBIT_CYC + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   ps2_state_e        state_reg, state_next;
   logic [10:0]       frame_reg;
   logic [7:0]        data_reg;
   logic [3:0]        bit_cnt_reg;
   logic [INH_W-1:0]  inh_cnt_reg;
   logic [TO_W-1:0]   to_cnt_reg;
   logic [1:0]        ps2d_sync_reg;

   logic              ps2c_filt;
   logic              ps2c_fall;
   logic              ps2d_s;
   logic              timeout;
   logic              fail;
   logic              retry_left;
   logic              wait_active;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .Reloj     (Reloj),
      .RST       (RST),
      .ps2c_in   (ps2c_in),
      .ps2c_filt (ps2c_filt),
      .ps2c_fall (ps2c_fall)
   );

   assign ps2d_s      = ps2d_sync_reg[1];
   assign timeout     = (to_cnt_reg == TO_W'(TIMEOUT_CYC));
   // States in which the device owes us clock activity.
   assign wait_active = (state_reg == RTS) || (state_reg == SEND) ||
                        (state_reg == ACK) || (state_reg == WAIT_IDLE);

`ifdef PS2_TX_RETRY_EN
   logic [1:0] retry_cnt_reg;

   always_ff @(posedge Reloj or negedge RST) begin
      if (!RST) begin
         retry_cnt_reg <= 2'd0;
      end else if (state_reg == IDLE) begin
         retry_cnt_reg <= 2'd0;
      end else if (fail && retry_left) begin
         retry_cnt_reg <= retry_cnt_reg + 2'd1;
      end
   end

   assign retry_left = (retry_cnt_reg != RETRY_MAX);
`else
   assign retry_left = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge Reloj or negedge RST) begin
      if (!RST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state and outputs
   always_comb begin
      state_next = state_reg;
      ps2c_oe    = 1'b0;
      ps2d_oe    = 1'b0;
      BUSY       = 1'b0;
      TX_DONE    = 1'b0;
      TX_ERR     = 1'b0;
      fail       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (WR) begin
               state_next = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2c_oe = 1'b1;
            BUSY    = 1'b1;
            if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
               state_next = RTS;
            end
         end
         RTS: begin
            ps2c_oe = 1'b1;
            ps2d_oe = ~frame_reg[0];
            BUSY    = 1'b1;
            if (timeout) begin
               fail = 1'b1;
            end else begin
               state_next = SEND;
            end
         end
         SEND: begin
            ps2d_oe = ~frame_reg[0];
            BUSY    = 1'b1;
            if (timeout) begin
               fail = 1'b1;
            end else if (ps2c_fall && bit_cnt_reg == 4'd9) begin
               state_next = ACK;
            end
         end
         ACK: begin
            BUSY = 1'b1;
            if (timeout) begin
               fail = 1'b1;
            end else if (ps2c_fall) begin
               if (ps2d_s) begin
                  fail = 1'b1;
               end else begin
                  state_next = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            BUSY = 1'b1;
            if (timeout) begin
               fail = 1'b1;
            end else if (ps2c_filt && ps2d_s) begin
               state_next = DONE;
            end
         end
         DONE: begin
            TX_DONE    = 1'b1;
            state_next = IDLE;
         end
         ERR: begin
            TX_ERR     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (fail) begin
         state_next = retry_left ? INHIBIT : ERR;
      end
   end

   // Datapath: byte latch, frame shifter, counters, data-line synchroniser
   always_ff @(posedge Reloj or negedge RST) begin
      if (!RST) begin
         frame_reg     <= '1;
         data_reg      <= '0;
         bit_cnt_reg   <= '0;
         inh_cnt_reg   <= '0;
         to_cnt_reg    <= '0;
         ps2d_sync_reg <= 2'b11;
      end else begin
         ps2d_sync_reg <= {ps2d_sync_reg[0], ps2d_in};

         if (state_reg == IDLE && WR) begin
            data_reg <= DATA_TX;
         end

         if (state_reg == INHIBIT) begin
            inh_cnt_reg <= inh_cnt_reg + 1'b1;
         end else begin
            inh_cnt_reg <= '0;
         end

         // Starts at 0 in RTS so it reads N exactly N cycles after release.
         if (wait_active) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end else begin
            to_cnt_reg <= '0;
         end

         // Reloaded on every inhibit so a retry resends the same byte.
         if (state_reg == INHIBIT) begin
            frame_reg   <= make_frame(data_reg);
            bit_cnt_reg <= '0;
         end else if (state_reg == SEND && ps2c_fall) begin
            frame_reg   <= {1'b1, frame_reg[10:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx. A behavioural device model drives the
// open-drain lines (wired-AND with the DUT's oe outputs), clocks the frame,
// reads each bit while its clock is low, and ACKs, NAKs or stays silent.
// Table vectors cover the named commands and corner cases; random bytes are
// checked against a parity/frame model built from the byte arithmetic.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 150;
   localparam int TO   = 4000;
   localparam int FLT  = 8;
   localparam int HALF = 30;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
`else
   localparam int ATTEMPTS = 1;
`endif
   localparam logic [1:0] M_ACK = 2'd0, M_NAK = 2'd1, M_SILENT = 2'd2;

   logic       Reloj = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] DATA_TX = 8'h00;
   logic       WR = 1'b0;
   logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, BUSY, TX_DONE, TX_ERR;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   assign ps2c_in = ~(ps2c_oe | dev_clk_low);
   assign ps2d_in = ~(ps2d_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYC (INH),
      .TIMEOUT_CYC (TO),
      .FILTER_LEN  (FLT)
   ) dut (
      .Reloj   (Reloj),
      .RST     (RST),
      .DATA_TX (DATA_TX),
      .WR      (WR),
      .ps2c_in (ps2c_in),
      .ps2d_in (ps2d_in),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe),
      .BUSY    (BUSY),
      .TX_DONE (TX_DONE),
      .TX_ERR  (TX_ERR)
   );

   always #5 Reloj = ~Reloj;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   both_cnt = 0;
   int   inh_starts = 0;
   logic c_oe_q = 1'b0;

   // Event monitor, sampled 1 time unit after each rising edge.
   always @(posedge Reloj) begin
      #1;
      cyc++;
      if (TX_DONE) done_cnt++;
      if (TX_ERR) err_cnt++;
      if (TX_DONE && TX_ERR) both_cnt++;
      if (ps2c_oe && !c_oe_q) inh_starts++;
      c_oe_q = ps2c_oe;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One attempt as seen by the device. Returns the 10 bits read on falls
   // 1..10, the inhibit length, and the cycle at which the clock was released.
   task automatic device_attempt(input logic [1:0] mode, input int wr_at, input int rst_at,
                                 output logic [9:0] bits, output int inh_len,
                                 output int rel_cyc, output bit aborted);
      int guard;
      bits = '0;
      inh_len = 0;
      rel_cyc = 0;
      aborted = 1'b0;
      guard = 0;
      while (!ps2c_oe && guard < 1000) begin
         @(negedge Reloj);
         guard++;
      end
      chk("inhibit_start", ps2c_oe, 1);
      while (ps2c_oe && !ps2d_oe && inh_len < INH + 100) begin
         inh_len++;
         @(negedge Reloj);
      end
      chk("rts_both_low", {ps2c_oe, ps2d_oe}, 2'b11);
      @(negedge Reloj);
      chk("start_bit_release", {ps2c_oe, ps2d_oe}, 2'b01);
      rel_cyc = cyc;
      if (mode == M_SILENT) return;
      repeat (20) @(negedge Reloj);
      for (int k = 1; k <= 11; k++) begin
         if (k == 11 && mode == M_ACK) dev_dat_low = 1'b1;
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge Reloj);
         if (k <= 10) bits[k-1] = ps2d_in;
         if (k == rst_at) begin
            chk("pre_reset_dat_oe", ps2d_oe, 1);
            RST = 1'b0;
            #1;
            chk("async_reset_lines", {ps2c_oe, ps2d_oe, BUSY}, 3'b000);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            aborted = 1'b1;
            return;
         end
         if (k == wr_at) begin
            DATA_TX = CMD_ENABLE;
            WR = 1'b1;
            @(negedge Reloj);
            WR = 1'b0;
         end
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge Reloj);
      end
      dev_dat_low = 1'b0;
   endtask

   task automatic run_xfer(input logic [7:0] d, input logic [1:0] mode, input logic exp_par,
                           input int exp_done, input int exp_err, input int wr_at, input int rst_at);
      logic [9:0] bits;
      int         inh_len, rel, d0, e0, i0, guard, n_att;
      bit         ab;
      ab = 1'b0;
      chk("idle_before_wr", {ps2c_oe, BUSY}, 2'b00);
      d0 = done_cnt;
      e0 = err_cnt;
      i0 = inh_starts;
      DATA_TX = d;
      WR = 1'b1;
      @(negedge Reloj);
      WR = 1'b0;
      DATA_TX = ~d;
      chk("wr_latency", {ps2c_oe, BUSY}, 2'b11);
      n_att = (mode == M_ACK) ? 1 : ATTEMPTS;
      for (int a = 0; a < n_att; a++) begin
         device_attempt(mode, wr_at, rst_at, bits, inh_len, rel, ab);
         if (ab) break;
         if (a == 0) chk("inhibit_len", inh_len, INH);
         if (mode != M_SILENT) begin
            chk("data_bits", bits[7:0], d);
            chk("parity_fall9", bits[8], exp_par);
            chk("stop_fall10", bits[9], 1);
         end else begin
            guard = 0;
            while (!ps2c_oe && !TX_ERR && guard < TO + 100) begin
               @(negedge Reloj);
               guard++;
            end
            chk("timeout_cycles", cyc - rel, TO);
         end
      end
      if (ab) begin
         repeat (3) @(negedge Reloj);
         chk("reset_hold", {ps2c_oe, ps2d_oe, BUSY, TX_DONE, TX_ERR}, 5'b0);
         chk("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
         RST = 1'b1;
         repeat (5) @(negedge Reloj);
         $display("XFER data=%02h aborted by reset", d);
         return;
      end
      guard = 0;
      while (done_cnt == d0 && err_cnt == e0 && guard < 3000) begin
         @(negedge Reloj);
         guard++;
      end
      chk("result_seen", (done_cnt != d0) || (err_cnt != e0), 1);
      repeat (50) @(negedge Reloj);
      chk("done_pulses", done_cnt - d0, exp_done);
      chk("err_pulses", err_cnt - e0, exp_err);
      chk("lines_idle", {ps2c_oe, ps2d_oe, BUSY}, 3'b000);
      chk("inhibit_count", inh_starts - i0, n_att);
      $display("XFER data=%02h mode=%0d done=%0d err=%0d attempts=%0d",
               d, mode, done_cnt - d0, err_cnt - e0, inh_starts - i0);
   endtask

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] mode;
      logic       par;
      logic       done;
      logic       err;
      logic [3:0] wr_at;
   } vec_t;

   vec_t       vt[7];
   logic [7:0] rd;
   logic [1:0] rm;
   logic       rpar;

   initial begin
      vt[0] = '{CMD_SET_LED, M_ACK,    1'b1, 1'b1, 1'b0, 4'd0};
      vt[1] = '{CMD_RESET,   M_ACK,    1'b1, 1'b1, 1'b0, 4'd0};
      vt[2] = '{8'h00,       M_ACK,    1'b1, 1'b1, 1'b0, 4'd0};
      vt[3] = '{8'h01,       M_ACK,    1'b0, 1'b1, 1'b0, 4'd0};
      vt[4] = '{CMD_ENABLE,  M_NAK,    1'b0, 1'b0, 1'b1, 4'd0};
      vt[5] = '{CMD_RESET,   M_SILENT, 1'b1, 1'b0, 1'b1, 4'd0};
      vt[6] = '{CMD_SET_LED, M_ACK,    1'b1, 1'b1, 1'b0, 4'd5};

      RST = 1'b0;
      repeat (3) @(negedge Reloj);
      chk("reset_state", {ps2c_oe, ps2d_oe, BUSY, TX_DONE, TX_ERR}, 5'b0);
      RST = 1'b1;
      repeat (20) @(negedge Reloj);

      for (int i = 0; i < 7; i++) begin
         run_xfer(vt[i].data, vt[i].mode, vt[i].par, int'(vt[i].done), int'(vt[i].err),
                  int'(vt[i].wr_at), 0);
      end

      // Reset in the middle of the frame, then a clean transfer.
      run_xfer(CMD_SET_LED, M_ACK, 1'b1, 1, 0, 0, 5);
      run_xfer(CMD_ENABLE, M_ACK, 1'b0, 1, 0, 0, 0);

      // Random bytes: odd parity means the frame's data+parity has an odd count of ones.
      for (int r = 0; r < 8; r++) begin
         rd   = 8'($urandom);
         rm   = ($urandom_range(0, 3) == 0) ? M_NAK : M_ACK;
         rpar = (($countones(rd) % 2) == 0);
         run_xfer(rd, rm, rpar, (rm == M_ACK) ? 1 : 0, (rm == M_NAK) ? 1 : 0, 0, 0);
      end

      chk("never_done_and_err", both_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
